// File: rtl/gpu_cmd_sequencer.sv
// gpu_cmd_sequencer: assembles FIFO words into rasterizer commands; define GPU_POLYLINE_EN for terminator-delimited polylines
module gpu_cmd_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_data,
  output logic        fifo_re,
  input  logic        cmd_flush,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [4:0]  cmd_len,
  input  logic [3:0]  param_addr,
  output logic [31:0] param_data,
  output logic        bad_cmd,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
  state_t state, state_nxt;
  logic [31:0] buffer [16];
  logic [4:0] word_cnt, len_req, op_len, vtx, tri_len;
  logic [7:0] op;
  logic poly, op_poly, op_ok, term, wr, ovf;
  assign op = fifo_data[31:24];
  assign vtx = op[3] ? 5'd4 : 5'd3;
  assign tri_len = 5'd1 + (op[2] ? vtx << 1 : vtx) + (op[4] ? vtx - 5'd1 : 5'd0);
  assign op_len = op == 8'h02 ? 5'd3
                : op[7:5] == 3'b001 ? tri_len
                : op[7:5] == 3'b010 ? 5'd3 + {4'd0, op[4]}
                : op[7:5] == 3'b011 ? 5'd2 + {4'd0, op[2]} + {4'd0, op[4:3] == 2'b00}
                : op[7:5] == 3'b100 ? 5'd4
                : op >= 8'hA0 && op <= 8'hDF ? 5'd3
                : op == 8'h01 || (op >= 8'hE1 && op <= 8'hE6) ? 5'd1
                : 5'd0;
  assign op_ok = op_len != 5'd0;
`ifdef GPU_POLYLINE_EN
  assign op_poly = op[7:5] == 3'b010 && op[3];
`else
  assign op_poly = 1'b0;
`endif
  assign term = (fifo_data & 32'hF000F000) == 32'h50005000;
  assign fifo_re = !fifo_empty && state != ISSUE && !cmd_flush && !rst;
  assign ovf = state == FETCH && fifo_re && poly && !term && word_cnt == 5'd15;
  assign busy = state != IDLE;
  assign param_data = buffer[param_addr];
  // next state and buffer write enable; flush overrides everything
  always_comb begin
    state_nxt = state;
    wr = 1'b0;
    case (state)
      IDLE: if (fifo_re && op_ok) begin
        wr = 1'b1;
        state_nxt = op_len == 5'd1 && !op_poly ? ISSUE : FETCH;
      end
      FETCH: if (fifo_re) begin
        wr = !(poly && term);
        state_nxt = (poly && (term || word_cnt == 5'd15)) || (!poly && word_cnt == len_req - 5'd1) ? ISSUE : FETCH;
      end
      ISSUE: if (cmd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (cmd_flush) state_nxt = IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // parameter buffer, not cleared by reset
  always_ff @(posedge clk) begin
    if (wr) buffer[word_cnt[3:0]] <= fifo_data;
  end
  // command bookkeeping, valid and error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= 5'd0;
      len_req <= 5'd0;
      poly <= 1'b0;
      cmd_op <= 8'h00;
      cmd_len <= 5'd0;
      cmd_valid <= 1'b0;
      bad_cmd <= 1'b0;
    end else begin
      cmd_valid <= state_nxt == ISSUE;
      bad_cmd <= (state == IDLE && fifo_re && !op_ok && op != 8'h00) || ovf;
      if (state_nxt == IDLE) word_cnt <= 5'd0;
      else if (wr) word_cnt <= word_cnt + 5'd1;
      if (state == IDLE && fifo_re && op_ok) begin
        cmd_op <= op;
        cmd_len <= op_len;
        len_req <= op_len;
        poly <= op_poly;
      end
      if (state == FETCH && state_nxt == ISSUE && poly) cmd_len <= word_cnt + {4'd0, wr};
    end
  end
endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// tb_gpu_cmd_sequencer: random and directed command streams checked against a queue-based command model
module tb_gpu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1, fifo_empty = 1'b0, cmd_flush = 1'b0, cmd_ready = 1'b0;
  logic [31:0] fifo_data = 32'h02000000;
  logic [3:0] param_addr = 4'd0;
  logic fifo_re, cmd_valid, bad_cmd, busy;
  logic [7:0] cmd_op;
  logic [4:0] cmd_len;
  logic [31:0] param_data;
  int total = 0, bad = 0;
  logic [31:0] q[$];
  logic [31:0] m_cur[$];
  bit m_pend = 0, m_bad = 0, m_poly = 0;
  int m_need = 0;
  int cyc = 0, n_bad = 0;
  int pop_cyc[$], v_cyc[$], hs_len[$], hs_op[$];
  int stall_pct = 0, ready_pct = 100, flush_pm = 0;
  bit force_stall = 0, force_flush = 0;
  always #5 clk = ~clk;
  gpu_cmd_sequencer dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_re(fifo_re),
    .cmd_flush(cmd_flush), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .param_addr(param_addr), .param_data(param_data), .bad_cmd(bad_cmd), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int len_of(input logic [7:0] op);
    int v, t, g;
    v = op[3] ? 4 : 3;
    t = int'(op[2]);
    g = int'(op[4]);
    if (op == 8'h00) return 0;
    if (op == 8'h01 || (op >= 8'hE1 && op <= 8'hE6)) return 1;
    if (op == 8'h02) return 3;
    if (op >= 8'h20 && op <= 8'h3F) return 1 + v * (1 + t) + g * (v - 1);
    if (op >= 8'h40 && op <= 8'h5F) return 3 + g;
    if (op >= 8'h60 && op <= 8'h7F) return 2 + t + int'(op[4:3] == 2'b00);
    if (op >= 8'h80 && op <= 8'h9F) return 4;
    if (op >= 8'hA0 && op <= 8'hDF) return 3;
    return -1;
  endfunction
  function automatic bit is_poly(input logic [7:0] op);
`ifdef GPU_POLYLINE_EN
    return (op >= 8'h48 && op <= 8'h4F) || (op >= 8'h58 && op <= 8'h5F);
`else
    return op == 8'h00 && op != 8'h00;
`endif
  endfunction
  task automatic step(input bit do_rst = 1'b0);
    bit e, fl, rd, ere, nb;
    logic [31:0] d;
    int l;
    @(posedge clk);
    #1;
    cyc++;
    e = q.size() == 0 || force_stall || $urandom_range(99) < stall_pct;
    d = q.size() != 0 ? q[0] : $urandom;
    fl = force_flush || $urandom_range(999) < flush_pm;
    rd = $urandom_range(99) < ready_pct;
    rst = do_rst; fifo_empty = e; fifo_data = d; cmd_flush = fl; cmd_ready = rd; param_addr = 4'($urandom);
    #1;
    ere = !e && !m_pend && !fl && !do_rst;
    check("fifo_re", fifo_re, ere);
    check("cmd_valid", cmd_valid, m_pend);
    check("bad_cmd", bad_cmd, m_bad);
    check("busy", busy, m_pend || m_cur.size() != 0);
    if (m_pend) begin
      check("cmd_op", cmd_op, m_cur[0][31:24]);
      check("cmd_len", cmd_len, m_cur.size());
      if (param_addr < m_cur.size()) check("param", param_data, m_cur[param_addr]);
    end
    if (fifo_re) begin
      pop_cyc.push_back(cyc);
      if (q.size() != 0) void'(q.pop_front());
    end
    if (cmd_valid) v_cyc.push_back(cyc);
    if (bad_cmd) n_bad++;
    if (cmd_valid && rd && !fl && !do_rst) begin
      hs_len.push_back(int'(cmd_len));
      hs_op.push_back(int'(cmd_op));
    end
    nb = 0;
    if (do_rst || fl) begin
      m_cur.delete();
      m_pend = 0;
    end else if (m_pend) begin
      if (rd) begin
        m_pend = 0;
        m_cur.delete();
      end
    end else if (ere) begin
      if (m_cur.size() == 0) begin
        l = len_of(d[31:24]);
        if (l < 0) nb = 1;
        else if (l > 0) begin
          m_cur.push_back(d);
          m_need = l;
          m_poly = is_poly(d[31:24]);
          m_pend = !m_poly && l == 1;
        end
      end else if (m_poly && (d & 32'hF000F000) == 32'h50005000) m_pend = 1;
      else begin
        m_cur.push_back(d);
        if (m_poly ? m_cur.size() == 16 : m_cur.size() == m_need) begin
          m_pend = 1;
          nb = m_poly;
        end
      end
    end
    m_bad = nb;
  endtask
  task automatic push_cmd(input logic [7:0] op);
    logic [31:0] w;
    q.push_back({op, 24'($urandom)});
    if (is_poly(op)) begin
      repeat ($urandom_range(1, 17)) begin
        w = $urandom;
        if ((w & 32'hF000F000) == 32'h50005000) w ^= 32'h10000000;
        q.push_back(w);
      end
      q.push_back(32'h50005000 | ($urandom & 32'h0FFF0FFF));
    end else
      for (int i = 1; i < len_of(op); i++) q.push_back($urandom);
  endtask
  task automatic drain();
    for (int i = 0; i < 5000 && (q.size() != 0 || m_pend); i++) step();
    check("drain_timeout", q.size() != 0 || m_pend, 0);
  endtask
  task automatic wait_pend();
    for (int i = 0; i < 100 && !m_pend; i++) step();
    check("pend_timeout", m_pend, 1);
  endtask
  task automatic clr();
    pop_cyc.delete(); v_cyc.delete(); hs_len.delete(); hs_op.delete();
    n_bad = 0;
    stall_pct = 0; ready_pct = 100; flush_pm = 0;
  endtask
  initial begin
    step(1'b1);
    step(1'b1);
    @(posedge clk);
    #2;
    check("rst_op", cmd_op, 8'h00);
    check("rst_len", cmd_len, 5'd0);
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_re", fifo_re, 1'b0);
    clr();
    q.push_back(32'h20FF0000); q.push_back(32'h00100010); q.push_back(32'h00200020); q.push_back(32'h00300010);
    drain();
    check("t23_pops", pop_cyc.size(), 4);
    check("t23_consec", pop_cyc.size() == 4 ? pop_cyc[3] - pop_cyc[0] : -1, 3);
    check("t23_vcyc", v_cyc.size(), 1);
    check("t23_vtime", v_cyc.size() != 0 && pop_cyc.size() == 4 ? v_cyc[0] - pop_cyc[3] : -1, 1);
    check("t23_op", hs_op.size() != 0 ? hs_op[0] : -1, 8'h20);
    check("t23_len", hs_len.size() != 0 ? hs_len[0] : -1, 4);
    clr();
    ready_pct = 0;
    q.push_back(32'h3C000000);
    for (int i = 1; i < 12; i++) q.push_back(32'h00010001 * i);
    q.push_back(32'h01000000);
    wait_pend();
    repeat (5) step();
    check("t24_hold_q", q.size(), 1);
    ready_pct = 100;
    drain();
    check("t24_len", hs_len.size() == 2 ? hs_len[0] : -1, 12);
    check("t24_next", hs_op.size() == 2 ? hs_op[1] : -1, 8'h01);
    clr();
    q.push_back(32'h02000000);
    step();
    force_stall = 1;
    repeat (3) step();
    check("t25_stall_busy", busy, 1'b1);
    force_stall = 0;
    q.push_back(32'hAAAA5555); q.push_back(32'h12345678);
    drain();
    check("t25_len", hs_len.size() == 1 ? hs_len[0] : -1, 3);
    clr();
    q.push_back(32'hFF000000); q.push_back(32'h00000000); q.push_back(32'hE1000400);
    drain();
    repeat (2) step();
    check("t26_bad", n_bad, 1);
    check("t26_n", hs_op.size(), 1);
    check("t26_op", hs_op.size() == 1 ? hs_op[0] : -1, 8'hE1);
    check("t26_len", hs_len.size() == 1 ? hs_len[0] : -1, 1);
    clr();
    ready_pct = 0;
    q.push_back(32'h60000000); q.push_back(32'h11111111); q.push_back(32'h22222222);
    repeat (2) step();
    force_flush = 1;
    step();
    force_flush = 0;
    q.delete();
    step();
    q.push_back(32'h60000000); q.push_back(32'h11111111); q.push_back(32'h22222222);
    wait_pend();
    step(1'b1);
    step();
    q.push_back(32'h01000000);
    ready_pct = 100;
    drain();
    check("t27_n", hs_op.size(), 1);
    check("t27_op", hs_op.size() == 1 ? hs_op[0] : -1, 8'h01);
    check("t27_len", hs_len.size() == 1 ? hs_len[0] : -1, 1);
    clr();
    q.push_back(32'h48000000);
    for (int i = 1; i <= 5; i++) q.push_back(32'h01000000 | i);
    q.push_back(32'h55555555);
    repeat (3) q.push_back(32'h01000000);
    drain();
    check("t28_op", hs_op.size() != 0 ? hs_op[0] : -1, 8'h48);
`ifdef GPU_POLYLINE_EN
    check("t28_n", hs_len.size(), 4);
    check("t28_len", hs_len.size() != 0 ? hs_len[0] : -1, 6);
`else
    check("t28_n", hs_len.size(), 5);
    check("t28_len", hs_len.size() != 0 ? hs_len[0] : -1, 3);
    check("t28_tail", hs_len.size() == 5 ? hs_len[4] : -1, 4);
`endif
    clr();
    stall_pct = 25; ready_pct = 50; flush_pm = 20;
    for (int n = 0; n < 300; n++) begin
      push_cmd(8'($urandom));
      for (int i = 0; i < 500 && q.size() > 8; i++) step($urandom_range(299) == 0);
    end
    flush_pm = 0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
